// File: rtl/logical_arb.sv
// Two-requester round-robin front end for a shared combinational logical unit.
// One operation in flight: grant, execute, then hold the response until accepted.
module logical_arb #(
    parameter int unsigned TAG_W = 4,
    parameter int unsigned NREQ  = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic [NREQ-1:0]  req_valid_i,
    output logic [NREQ-1:0]  req_ready_o,
    input  logic [3:0]       req0_funct_i,
    input  logic [3:0]       req1_funct_i,
    input  logic [31:0]      req0_op1_i,
    input  logic [31:0]      req0_op2_i,
    input  logic [31:0]      req1_op1_i,
    input  logic [31:0]      req1_op2_i,
    input  logic [TAG_W-1:0] req0_tag_i,
    input  logic [TAG_W-1:0] req1_tag_i,
    output logic [3:0]       lu_funct_o,
    output logic [31:0]      lu_op1_o,
    output logic [31:0]      lu_op2_o,
    input  logic [31:0]      lu_res_i,
    output logic [NREQ-1:0]  rsp_valid_o,
    input  logic [NREQ-1:0]  rsp_ready_i,
    output logic [31:0]      rsp_data_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic             rsp_err_o
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        HOLD
    } state_e;

    state_e           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             owner_q, owner_d;
    logic             err_q, err_d;
    logic [3:0]       funct_q, funct_d;
    logic [31:0]      op1_q, op1_d;
    logic [31:0]      op2_q, op2_d;
    logic [31:0]      res_q, res_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    logic             win;
    logic             sel_illegal;
    logic [3:0]       sel_funct;
    logic [31:0]      sel_op1;
    logic [31:0]      sel_op2;
    logic [TAG_W-1:0] sel_tag;

    // With both requesters valid the pointer decides; otherwise the lone valid one wins.
    always_comb begin
        win       = (&req_valid_i) ? ptr_q : req_valid_i[1];
        sel_funct = win ? req1_funct_i : req0_funct_i;
        sel_op1   = win ? req1_op1_i   : req0_op1_i;
        sel_op2   = win ? req1_op2_i   : req0_op2_i;
        sel_tag   = win ? req1_tag_i   : req0_tag_i;
        case (sel_funct)
            4'h2, 4'h3, 4'h4, 4'h6, 4'h7: sel_illegal = 1'b0;
            default:                      sel_illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        err_d       = err_q;
        funct_d     = funct_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        res_d       = res_q;
        tag_d       = tag_q;
        req_ready_o = '0;
        rsp_valid_o = '0;
        case (state_q)
            IDLE: begin
                if (!flush_i && (|req_valid_i)) begin
                    req_ready_o[win] = 1'b1;
                    owner_d          = win;
                    ptr_d            = ~win;
                    err_d            = sel_illegal;
                    funct_d          = sel_illegal ? 4'h4 : sel_funct;
                    op1_d            = sel_op1;
                    op2_d            = sel_op2;
                    tag_d            = sel_tag;
                    state_d          = EXEC;
                end
            end
            EXEC: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    res_d   = err_q ? '0 : lu_res_i;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    rsp_valid_o[owner_q] = 1'b1;
                    if (rsp_ready_i[owner_q]) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            err_q   <= 1'b0;
            funct_q <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            res_q   <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            err_q   <= err_d;
            funct_q <= funct_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            res_q   <= res_d;
            tag_q   <= tag_d;
        end
    end

    assign lu_funct_o = funct_q;
    assign lu_op1_o   = op1_q;
    assign lu_op2_o   = op2_q;
    assign rsp_data_o = res_q;
    assign rsp_tag_o  = tag_q;
    assign rsp_err_o  = err_q;

endmodule

// File: tb/tb_logical_arb.sv
// Directed bench for logical_arb: transaction-level model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_logical_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  f0, f1;
    logic [31:0] a0, b0, a1, b1;
    logic [3:0]  t0, t1;
    logic [3:0]  lu_funct;
    logic [31:0] lu_op1, lu_op2, lu_res;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_tag;
    logic        rsp_err;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    logical_arb #(.TAG_W(4), .NREQ(2)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .flush_i      (flush),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req0_funct_i (f0),
        .req1_funct_i (f1),
        .req0_op1_i   (a0),
        .req0_op2_i   (b0),
        .req1_op1_i   (a1),
        .req1_op2_i   (b1),
        .req0_tag_i   (t0),
        .req1_tag_i   (t1),
        .lu_funct_o   (lu_funct),
        .lu_op1_o     (lu_op1),
        .lu_op2_o     (lu_op2),
        .lu_res_i     (lu_res),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_data_o   (rsp_data),
        .rsp_tag_o    (rsp_tag),
        .rsp_err_o    (rsp_err)
    );

    // Shared logical unit; unknown selects return a marker so a missing zero-force shows.
    always_comb begin
        case (lu_funct)
            4'h2:    lu_res = ($signed(lu_op1) < $signed(lu_op2)) ? 32'd1 : 32'd0;
            4'h3:    lu_res = (lu_op1 < lu_op2) ? 32'd1 : 32'd0;
            4'h4:    lu_res = lu_op1 ^ lu_op2;
            4'h6:    lu_res = lu_op1 | lu_op2;
            4'h7:    lu_res = lu_op1 & lu_op2;
            default: lu_res = 32'hDEAD_BEEF;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {err, data} for one operation as the requester should see it.
    function automatic logic [32:0] op_result(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            4'h2:    return {1'b0, (($signed(a) < $signed(b)) ? 32'd1 : 32'd0)};
            4'h3:    return {1'b0, ((a < b) ? 32'd1 : 32'd0)};
            4'h4:    return {1'b0, a ^ b};
            4'h6:    return {1'b0, a | b};
            4'h7:    return {1'b0, a & b};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    // Model: an operation is busy from the cycle after its grant; the response
    // is due from the second cycle after the grant until the owner accepts.
    logic        m_busy = 1'b0;
    int unsigned m_age = 0;
    logic        m_owner = 1'b0;
    logic        m_ptr = 1'b0;
    logic        m_err = 1'b0;
    logic [31:0] m_data = '0;
    logic [3:0]  m_tag = '0;
    logic [3:0]  m_lu_f = '0;
    logic [31:0] m_op1 = '0;
    logic [31:0] m_op2 = '0;

    always @(negedge clk) begin
        logic [1:0]  exp_ready;
        logic [1:0]  exp_rv;
        logic        w;
        logic [32:0] r;
        if (!rst_n) begin
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_rsp_data", rsp_data, 32'd0);
            chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
            chk("rst_rsp_err", 32'(rsp_err), 32'd0);
            chk("rst_lu", {28'd0, lu_funct} | lu_op1 | lu_op2, 32'd0);
            m_busy = 1'b0;
            m_ptr  = 1'b0;
        end else begin
            exp_ready = 2'b00;
            w = 1'b0;
            if (!m_busy && !flush && req_valid != 2'b00) begin
                if (req_valid == 2'b11) w = m_ptr;
                else if (req_valid == 2'b10) w = 1'b1;
                else w = 1'b0;
                exp_ready = w ? 2'b10 : 2'b01;
            end
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            exp_rv = (m_busy && m_age >= 2 && !flush) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            if (exp_rv != 2'b00) begin
                chk("rsp_data", rsp_data, m_data);
                chk("rsp_tag", 32'(rsp_tag), 32'(m_tag));
                chk("rsp_err", 32'(rsp_err), 32'(m_err));
            end
            if (m_busy && m_age == 1) begin
                chk("lu_funct", 32'(lu_funct), 32'(m_lu_f));
                chk("lu_op1", lu_op1, m_op1);
                chk("lu_op2", lu_op2, m_op2);
            end
            if (flush) begin
                m_busy = 1'b0;
            end else if (exp_ready != 2'b00) begin
                m_busy  = 1'b1;
                m_age   = 1;
                m_owner = w;
                m_ptr   = ~w;
                m_op1   = w ? a1 : a0;
                m_op2   = w ? b1 : b0;
                m_tag   = w ? t1 : t0;
                r       = op_result(w ? f1 : f0, m_op1, m_op2);
                m_err   = r[32];
                m_data  = r[31:0];
                m_lu_f  = r[32] ? 4'h4 : (w ? f1 : f0);
            end else if (m_busy) begin
                if (m_age >= 2 && rsp_ready[m_owner]) m_busy = 1'b0;
                else m_age++;
            end
        end
    end

    // Advance one cycle; a requester drops valid once it has been granted.
    task automatic step();
        logic [1:0] g;
        #1 g = req_ready;
        @(posedge clk);
        #1 req_valid = req_valid & ~g;
    endtask

    task automatic put(input int unsigned idx, input logic [3:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] t);
        if (idx == 0) begin
            f0 = f; a0 = a; b0 = b; t0 = t; req_valid[0] = 1'b1;
        end else begin
            f1 = f; a1 = a; b1 = b; t1 = t; req_valid[1] = 1'b1;
        end
    endtask

    task automatic chk_rsp(input string name, input logic [1:0] rv, input logic [31:0] d,
                           input logic [3:0] t, input logic e);
        chk({name, "_valid"}, 32'(rsp_valid), 32'(rv));
        chk({name, "_data"}, rsp_data, d);
        chk({name, "_tag"}, 32'(rsp_tag), 32'(t));
        chk({name, "_err"}, 32'(rsp_err), 32'(e));
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
        f0 = '0; f1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0; t0 = '0; t1 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", 32'(req_ready), 32'd0);
        chk_rsp("reset_rsp", 2'b00, 32'd0, 4'd0, 1'b0);
        rst_n = 1'b1;

        // Single XOR
        put(0, 4'h4, 32'hF0F0_0000, 32'h0FF0_0000, 4'd3);
        rsp_ready = 2'b11;
        #1 chk("xor_grant", 32'(req_ready), 32'd1);
        step();
        #1 chk("xor_exec_rv", 32'(rsp_valid), 32'd0);
        step();
        #1 chk_rsp("xor", 2'b01, 32'hFF00_0000, 4'd3, 1'b0);
        step();

        // Fresh reset so the pointer starts at requester 0
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;

        // Contention, then SLT and SLTU on requester 1
        put(0, 4'h6, 32'h1234_0000, 32'h0000_5678, 4'd5);
        put(1, 4'h2, 32'hFFFF_FFFF, 32'h0000_0001, 4'd9);
        #1 chk("cont_grant0", 32'(req_ready), 32'd1);
        step(); step();
        #1 chk_rsp("cont_or", 2'b01, 32'h1234_5678, 4'd5, 1'b0);
        step();
        #1 chk("cont_grant1", 32'(req_ready), 32'd2);
        step(); step();
        #1 chk_rsp("slt", 2'b10, 32'd1, 4'd9, 1'b0);
        put(1, 4'h3, 32'hFFFF_FFFF, 32'h0000_0001, 4'd10);
        step();
        #1 chk("sltu_grant", 32'(req_ready), 32'd2);
        step(); step();
        #1 chk_rsp("sltu", 2'b10, 32'd0, 4'd10, 1'b0);
        step();

        // Back-pressure with a competing request and non-owner ready
        put(0, 4'h7, 32'hFFFF_0000, 32'h0F0F_0F0F, 4'd7);
        rsp_ready = 2'b00;
        step(); step();
        put(1, 4'h4, 32'd1, 32'd3, 4'd2);
        rsp_ready = 2'b10;
        for (int i = 0; i < 10; i++) begin
            #1 chk_rsp("bp_hold", 2'b01, 32'h0F0F_0000, 4'd7, 1'b0);
            chk("bp_ready", 32'(req_ready), 32'd0);
            step();
        end
        rsp_ready = 2'b01;
        #1 chk("bp_last_rv", 32'(rsp_valid), 32'd1);
        step();
        #1 chk("bp_released_rv", 32'(rsp_valid), 32'd0);
        chk("bp_next_grant", 32'(req_ready), 32'd2);
        rsp_ready = 2'b11;
        step(); step();
        #1 chk_rsp("bp_req1", 2'b10, 32'd2, 4'd2, 1'b0);
        step();

        // Illegal funct
        put(0, 4'h1, 32'hAAAA_0000, 32'h0000_5555, 4'd12);
        #1 chk("ill_grant", 32'(req_ready), 32'd1);
        step();
        #1 chk("ill_lu_funct", 32'(lu_funct), 32'h4);
        step();
        #1 chk_rsp("ill", 2'b01, 32'd0, 4'd12, 1'b1);
        step();

        // Flush in EXEC; pointer now favours requester 1
        put(0, 4'h4, 32'h0000_00FF, 32'h0000_0F0F, 4'd1);
        put(1, 4'h6, 32'h0000_00F0, 32'h0000_000F, 4'd8);
        #1 chk("fl_grant1", 32'(req_ready), 32'd2);
        step();
        flush = 1'b1;
        #1 chk("fl_exec_rv", 32'(rsp_valid), 32'd0);
        step();
        put(1, 4'h6, 32'h0000_00F0, 32'h0000_000F, 4'd8);
        #1 chk("fl_idle_ready", 32'(req_ready), 32'd0);
        flush = 1'b0;
        #1 chk("fl_regrant0", 32'(req_ready), 32'd1);
        step(); step();
        #1 chk_rsp("fl_xor", 2'b01, 32'h0000_0FF0, 4'd1, 1'b0);
        step();
        #1 chk("fl_grant1_again", 32'(req_ready), 32'd2);
        step(); step();
        #1 chk_rsp("fl_or", 2'b10, 32'h0000_00FF, 4'd8, 1'b0);
        step();

        // Asynchronous reset in HOLD, then a fresh SLT
        put(0, 4'h2, 32'd5, 32'd7, 4'd4);
        rsp_ready = 2'b00;
        step(); step();
        #1 chk("ar_hold_rv", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1 chk_rsp("ar_reset", 2'b00, 32'd0, 4'd0, 1'b0);
        chk("ar_lu", {28'd0, lu_funct} | lu_op1 | lu_op2, 32'd0);
        step();
        rst_n = 1'b1;
        put(0, 4'h2, 32'h8000_0000, 32'd0, 4'd6);
        rsp_ready = 2'b01;
        #1 chk("ar_grant", 32'(req_ready), 32'd1);
        step(); step();
        #1 chk_rsp("ar_slt", 2'b01, 32'd1, 4'd6, 1'b0);
        step();
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/logical_arb.md
LOGICAL_ARB -- requirements
Module: logical_arb

Interface
REQ-001 SHALL have parameter TAG_W, default 4, width of the requester transaction tag.
REQ-002 SHALL have parameter NREQ, fixed at 2, number of requesters; other values are unsupported.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port flush_i  input  1  synchronous abort of any in-flight operation.
REQ-006 SHALL have port req_valid_i  input  [1:0]  per-requester request valid.
REQ-007 SHALL have port req_ready_o  output  [1:0]  per-requester accept; high on a bit means that request is taken this cycle.
REQ-008 SHALL have ports req0_funct_i / req1_funct_i  input  4 each  operation select.
REQ-009 SHALL have ports req0_op1_i, req0_op2_i, req1_op1_i, req1_op2_i  input  32 each  operands.
REQ-010 SHALL have ports req0_tag_i / req1_tag_i  input  TAG_W each  transaction tags.
REQ-011 SHALL have ports lu_funct_o (4), lu_op1_o (32), lu_op2_o (32)  output  drive the shared logical unit.
REQ-012 SHALL have port lu_res_i  input  32  combinational result from the logical unit.
REQ-013 SHALL have port rsp_valid_o  output  [1:0]  one-hot response valid toward the owning requester.
REQ-014 SHALL have port rsp_ready_i  input  [1:0]  per-requester response accept.
REQ-015 SHALL have ports rsp_data_o (32), rsp_tag_o (TAG_W), rsp_err_o (1)  output  shared response payload.

Function
REQ-016 SHALL implement FSM states IDLE, EXEC, HOLD.
REQ-017 In IDLE with any req_valid_i bit high, SHALL assert exactly one req_ready_o bit (the grant) in the same cycle, then go to EXEC.
REQ-018 SHALL assert req_ready_o only in IDLE with flush_i low; it SHALL be 2'b00 in EXEC and HOLD.
REQ-019 Arbitration SHALL be round-robin: a 1-bit priority pointer selects the winner when both are valid; after each grant the pointer SHALL point to the non-granted requester.
REQ-020 A single valid requester SHALL be granted regardless of the pointer.
REQ-021 On grant, SHALL register funct, op1, op2, tag and owner index; lu_* outputs SHALL be driven from these registers only.
REQ-022 Legal funct values SHALL be 4'h2 SLT, 4'h3 SLTU, 4'h4 XOR, 4'h6 OR, 4'h7 AND.
REQ-023 An illegal funct SHALL set a registered err bit; lu_funct_o SHALL then be driven as 4'h4 with data later forced to 0.
REQ-024 In EXEC, SHALL capture lu_res_i (or 0 if err) into the result register at the edge ending the cycle, then go to HOLD.
REQ-025 Latency SHALL be fixed: grant at edge N gives rsp_valid_o high from cycle N+2.
REQ-026 In HOLD, rsp_valid_o SHALL be one-hot at the owner index, with rsp_data_o/rsp_tag_o/rsp_err_o stable until accepted.
REQ-027 HOLD SHALL exit to IDLE when rsp_ready_i[owner] is high; rsp_ready_i of the non-owner SHALL be ignored.
REQ-028 Back-pressure SHALL be unbounded: HOLD persists with payload unchanged.
REQ-029 flush_i high SHALL force the next state to IDLE, clear rsp_valid_o, suppress grants, and leave the pointer unchanged; the flushed result is lost.
REQ-030 Requesters SHALL keep valid and payload stable until granted; a withdrawn request is not tracked.
REQ-031 Throughput SHALL be at most one operation per 3 cycles.

Reset
REQ-032 On rst_n_i low, state SHALL become IDLE, pointer 0, and all registers 0, asynchronously.
REQ-033 During reset, outputs SHALL be req_ready_o=0, rsp_valid_o=0, rsp_data_o=0, rsp_tag_o=0, rsp_err_o=0, lu_*=0.
REQ-034 Reset asserted mid-EXEC or mid-HOLD SHALL discard the operation with no response.

Verification
REQ-035 Single XOR: req0 funct 4'h4, op1 32'hF0F0_0000, op2 32'h0FF0_0000, tag 3 -> grant cycle 0; rsp_valid_o=2'b01 from cycle 2; data 32'hFF00_0000, tag 3, err 0.
REQ-036 Contention: both valid in IDLE after reset -> req0 granted first; after its response, req1 is granted (SLT op1 32'hFFFF_FFFF, op2 1 -> data 1); SLTU with the same operands -> data 0.
REQ-037 Back-pressure: rsp_ready_i=0 for 10 cycles in HOLD -> rsp_valid_o and payload stable for all 10; req_ready_o=0 throughout; released one cycle after rsp_ready_i[owner]=1.
REQ-038 Illegal funct 4'h1 -> rsp_err_o=1, rsp_data_o=0, correct tag.
REQ-039 flush_i pulsed in EXEC -> no rsp_valid_o, IDLE next cycle, pending request granted per the unchanged pointer.
REQ-040 rst_n_i dropped asynchronously in HOLD -> all outputs 0 immediately; after release, a fresh SLT completes normally.
